// File: rtl/async_fifo_pkg.sv
// Shared helpers for async_fifo: address/pointer width calculation and
// gray-code conversion used by the FIFO pointers.
package async_fifo_pkg;

    // Working width for the gray-code helpers; callers zero-extend/truncate.
    localparam int GRAY_W = 32;

    // Address width needed to index a memory of 'depth' entries.
    function automatic int addr_w_f(input int depth);
        return $clog2(depth);
    endfunction

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w_f(input int depth);
        return addr_w_f(depth) + 32'sd1;
    endfunction

    // Binary to reflected gray code.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 32'd1);
    endfunction

    // Reflected gray code back to binary (zero-extended upper bits stay zero).
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Simple dual-port register array for async_fifo: one write port and one
// registered read port. Storage is not reset; only the read register is.
module async_fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Next memory contents: update only the addressed word on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage array; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Next read data: load the addressed word on a read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with gray-coded pointers and
// full/afull/aempty/empty flags. Define ASYNC_FIFO_SYNC_PTR_EN to route the
// opposite-side gray pointer through a 2-flop synchronizer before the flag
// compares (dual-clock-ready, conservative flag deassertion).
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_AFULL  = FIFO_DEPTH - 1,
    parameter int FIFO_AEMPTY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  afull,
    output logic                  aempty,
    output logic                  empty
);

    localparam int ADDR_W = addr_w_f(FIFO_DEPTH);
    localparam int PTR_W  = ptr_w_f(FIFO_DEPTH);

    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(FIFO_AFULL);
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(FIFO_AEMPTY);

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W-1:0] wgray_q, wgray_d, rgray_q, rgray_d;

    logic             wr_accept_s, rd_accept_s;
    logic             full_s, afull_s, aempty_s, empty_s;

    // Pointer views used by the flag logic (local or synchronized).
    logic [PTR_W-1:0] wgray_rd_s;   // write pointer as seen by read side
    logic [PTR_W-1:0] rgray_wr_s;   // read pointer as seen by write side
    logic [PTR_W-1:0] occ_rd_s;     // occupancy as seen by read side
    logic [PTR_W-1:0] occ_wr_s;     // occupancy as seen by write side

    // Reset gating keeps the memory untouched while reset is asserted.
    assign wr_accept_s = wr_en & ~full_s  & rst_n;
    assign rd_accept_s = rd_en & ~empty_s & rst_n;

    // Next pointer values: advance binary pointer and its gray copy on acceptance.
    always_comb begin
        wptr_d  = wptr_q;
        wgray_d = wgray_q;
        rptr_d  = rptr_q;
        rgray_d = rgray_q;
        if (wr_accept_s) begin
            wptr_d  = wptr_q + PTR_ONE;
            wgray_d = PTR_W'(bin2gray(GRAY_W'(wptr_d)));
        end else begin
            wptr_d  = wptr_q;
            wgray_d = wgray_q;
        end
        if (rd_accept_s) begin
            rptr_d  = rptr_q + PTR_ONE;
            rgray_d = PTR_W'(bin2gray(GRAY_W'(rptr_d)));
        end else begin
            rptr_d  = rptr_q;
            rgray_d = rgray_q;
        end
    end

    // Pointer registers; reset discards all stored data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= PTR_ZERO;
            wgray_q <= PTR_ZERO;
            rptr_q  <= PTR_ZERO;
            rgray_q <= PTR_ZERO;
        end else begin
            wptr_q  <= wptr_d;
            wgray_q <= wgray_d;
            rptr_q  <= rptr_d;
            rgray_q <= rgray_d;
        end
    end

`ifdef ASYNC_FIFO_SYNC_PTR_EN
    logic [PTR_W-1:0] wgray_s1_q, wgray_s1_d, wgray_s2_q, wgray_s2_d;
    logic [PTR_W-1:0] rgray_s1_q, rgray_s1_d, rgray_s2_q, rgray_s2_d;

    // Synchronizer shift: each gray pointer moves one stage per cycle.
    always_comb begin
        wgray_s1_d = wgray_q;
        wgray_s2_d = wgray_s1_q;
        rgray_s1_d = rgray_q;
        rgray_s2_d = rgray_s1_q;
    end

    // Two-flop synchronizers for the cross-side gray pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wgray_s1_q <= PTR_ZERO;
            wgray_s2_q <= PTR_ZERO;
            rgray_s1_q <= PTR_ZERO;
            rgray_s2_q <= PTR_ZERO;
        end else begin
            wgray_s1_q <= wgray_s1_d;
            wgray_s2_q <= wgray_s2_d;
            rgray_s1_q <= rgray_s1_d;
            rgray_s2_q <= rgray_s2_d;
        end
    end

    // Local pointer is used directly so own-side flag assertion stays immediate.
    assign wgray_rd_s = wgray_s2_q;
    assign rgray_wr_s = rgray_s2_q;
    assign occ_rd_s   = PTR_W'(gray2bin(GRAY_W'(wgray_s2_q))) - rptr_q;
    assign occ_wr_s   = wptr_q - PTR_W'(gray2bin(GRAY_W'(rgray_s2_q)));
`else
    assign wgray_rd_s = wgray_q;
    assign rgray_wr_s = rgray_q;
    assign occ_rd_s   = wptr_q - rptr_q;
    assign occ_wr_s   = wptr_q - rptr_q;
`endif

    // Status flags: full/empty from gray compare, afull/aempty from occupancy.
    always_comb begin
        empty_s  = (wgray_rd_s == rgray_q);
        full_s   = (wgray_q[PTR_W-1:PTR_W-2] == ~rgray_wr_s[PTR_W-1:PTR_W-2]) &&
                   (wgray_q[PTR_W-3:0] == rgray_wr_s[PTR_W-3:0]);
        afull_s  = (occ_wr_s >= AFULL_LVL);
        aempty_s = (occ_rd_s <= AEMPTY_LVL);
    end

    assign full   = full_s;
    assign afull  = afull_s;
    assign aempty = aempty_s;
    assign empty  = empty_s;

    async_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_accept_s),
        .waddr (wptr_q[ADDR_W-1:0]),
        .wdata (wr_data),
        .re    (rd_accept_s),
        .raddr (rptr_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo (default build). A queue-based reference
// model predicts rd_data and flags every cycle; a monitor compares them.
module tb_async_fifo;

    localparam int DW     = 4;
    localparam int DEPTH  = 8;
    localparam int AFULL  = DEPTH - 1;
    localparam int AEMPTY = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          full, afull, aempty, empty;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] rd;
        logic          full;
        logic          afull;
        logic          aempty;
        logic          empty;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_rd = '0;
    bit            model_done = 1'b0;

    async_fifo #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .FIFO_AFULL  (AFULL),
        .FIFO_AEMPTY (AEMPTY)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (full),
        .afull   (afull),
        .aempty  (aempty),
        .empty   (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: queue semantics evaluated at each rising edge.
    initial begin
        forever begin
            exp_t e;
            int   occ;
            bit   wr_ok, rd_ok;
            @(posedge clk);
            if (model_done) break;
            if (!rst_n) begin
                mq.delete();
                exp_rd = '0;
            end else begin
                wr_ok = wr_en && (mq.size() < DEPTH);
                rd_ok = rd_en && (mq.size() > 0);
                if (rd_ok) exp_rd = mq.pop_front();
                if (wr_ok) mq.push_back(wr_data);
            end
            occ      = mq.size();
            e.rd     = exp_rd;
            e.full   = (occ == DEPTH);
            e.afull  = (occ >= AFULL);
            e.aempty = (occ <= AEMPTY);
            e.empty  = (occ == 0);
            sbq.push_back(e);
        end
    end

    // Monitor: compare DUT outputs against the oldest prediction, mid-cycle.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("rd_data", int'(rd_data), int'(e.rd));
                check("full",    int'(full),    int'(e.full));
                check("afull",   int'(afull),   int'(e.afull));
                check("aempty",  int'(aempty),  int'(e.aempty));
                check("empty",   int'(empty),   int'(e.empty));
            end
        end
    end

    task automatic drive(input bit w, input logic [DW-1:0] d, input bit r);
        @(negedge clk);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
    endtask

    initial begin
        // Reset held for two edges.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Overfill: ten writes of (i+13) mod 16; last two are dropped.
        for (int i = 0; i < 10; i++) drive(1'b1, DW'((i + 13) % 16), 1'b0);
        // Drain: nine reads; the ninth hits empty and must hold rd_data.
        for (int i = 0; i < 9; i++) drive(1'b0, '0, 1'b1);

        // Fill to 4, then 20 cycles of simultaneous read/write.
        for (int i = 0; i < 4; i++) drive(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, DW'($urandom), 1'b1);

        // Drain to empty, then simultaneous request while empty.
        for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1);
        drive(1'b1, 4'hA, 1'b1);
        drive(1'b0, '0, 1'b0);

        // Fill to full, then simultaneous request while full.
        for (int i = 0; i < 8; i++) drive(1'b1, DW'($urandom), 1'b0);
        drive(1'b1, 4'h5, 1'b1);
        drive(1'b0, '0, 1'b0);

        // Drain, fill to 5, reset mid-operation, then write and read back.
        for (int i = 0; i < 9; i++) drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, DW'($urandom), 1'b0);
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 4'h9, 1'b0);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'b1 & ($urandom_range(0, 99) < 55), DW'($urandom),
                  1'b1 & ($urandom_range(0, 99) < 50));
        end

        drive(1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        model_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
